// File: rtl/watch_monitor.sv
// watch_monitor: change-trace monitor for parallel watched buses.
// Every value change on an armed, enabled channel becomes a pending event
// {channel, new value, timestamp}. A round-robin arbiter moves one pending
// event per cycle into a first-word-fall-through FIFO that a consumer
// drains over a valid/ready port. Changes that arrive while a channel's
// previous event is still pending overwrite it and raise a sticky flag.
module watch_monitor #(
  parameter int CHANNELS = 7,
  parameter int WIDTH    = 24,
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 32,
  localparam int CW      = $clog2(CHANNELS),
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] watch_in,
  input  logic                      enable,
  input  logic                      clear_overflow,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [CW-1:0]             ev_chan,
  output logic [WIDTH-1:0]          ev_data,
  output logic [TS_WIDTH-1:0]       ev_time,
  output logic                      ev_overflow,
  output logic [LW-1:0]             level
);

  localparam int AW = $clog2(DEPTH);
  // FIFO entry layout, most significant first: {chan, data, time}
  localparam int EW = CW + WIDTH + TS_WIDTH;

  // free-running timestamp and arming state
  logic [TS_WIDTH-1:0] ts_reg;
  logic                armed_reg;

  // per-channel view of the watched bus and its bookkeeping
  logic [WIDTH-1:0]    chan_in   [CHANNELS];
  logic [WIDTH-1:0]    shadow_reg[CHANNELS];
  logic [WIDTH-1:0]    pdata_reg [CHANNELS];
  logic [TS_WIDTH-1:0] ptime_reg [CHANNELS];
  logic [CHANNELS-1:0] pend_reg;
  logic [CHANNELS-1:0] detect;
  logic [CHANNELS-1:0] grant;
  logic [CHANNELS-1:0] coalesce;

  // arbiter state
  logic [CW-1:0]       rr_reg;
  logic [CW-1:0]       grant_idx;
  logic                grant_any;

  // event FIFO
  logic [EW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wr_ptr_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [LW-1:0]       level_reg;
  logic [EW-1:0]       head;
  logic                fifo_full;
  logic                can_push;
  logic                push;
  logic                pop;

  logic                ovf_reg;

  // Per-channel change detection, shadow capture and pending-event latch.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan_in[gi]  = watch_in[gi*WIDTH +: WIDTH];
      assign detect[gi]   = armed_reg && enable && (chan_in[gi] != shadow_reg[gi]);
      // A new change replacing an event that is not leaving this cycle
      // loses the older one; that is what the overflow flag reports.
      assign coalesce[gi] = detect[gi] && pend_reg[gi] && !grant[gi];

      // Shadow follows the bus every cycle; a detection always wins over a
      // grant, so the newest value stays pending while the old one is pushed.
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_reg[gi] <= '0;
          pend_reg[gi]   <= 1'b0;
          pdata_reg[gi]  <= '0;
          ptime_reg[gi]  <= '0;
        end else begin
          shadow_reg[gi] <= chan_in[gi];
          if (detect[gi]) begin
            pend_reg[gi]  <= 1'b1;
            pdata_reg[gi] <= chan_in[gi];
            ptime_reg[gi] <= ts_reg;
          end else if (grant[gi]) begin
            pend_reg[gi]  <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // Timestamp counter and the one-shot arming flag that suppresses the
  // spurious "change" from reset-valued shadows.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_reg    <= '0;
      armed_reg <= 1'b0;
    end else begin
      ts_reg    <= ts_reg + 1'b1;
      armed_reg <= 1'b1;
    end
  end

  // Round-robin search: walk offsets from the highest down so the pending
  // channel closest to rr (ascending, with wrap) is the one left standing.
  always_comb begin : arb_search
    logic [CW:0] sum;
    sum       = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      sum = {1'b0, rr_reg} + (CW+1)'(k);
      if (sum >= (CW+1)'(CHANNELS)) begin
        sum = sum - (CW+1)'(CHANNELS);
      end
      if (pend_reg[sum[CW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = sum[CW-1:0];
      end
    end
  end

  // FIFO acceptance: a full FIFO still takes a push when it pops the same cycle.
  assign fifo_full = (level_reg == LW'(DEPTH));
  assign pop       = ev_valid && ev_ready;
  assign can_push  = !fifo_full || pop;
  assign push      = grant_any && can_push;

  // One-hot grant seen by the per-channel pending logic.
  always_comb begin
    grant = '0;
    if (push) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Round-robin pointer moves just past the channel that was served.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_reg <= '0;
    end else if (push) begin
      rr_reg <= (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Event storage; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {grant_idx, pdata_reg[grant_idx], ptime_reg[grant_idx]};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Sticky overflow: a coalescing event outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (|coalesce) begin
      ovf_reg <= 1'b1;
    end else if (clear_overflow) begin
      ovf_reg <= 1'b0;
    end
  end

  // First-word-fall-through head, zeroed whenever nothing is valid.
  assign head        = mem[rd_ptr_reg];
  assign ev_valid    = (level_reg != '0);
  assign ev_chan     = ev_valid ? head[EW-1 -: CW]          : '0;
  assign ev_data     = ev_valid ? head[TS_WIDTH +: WIDTH]   : '0;
  assign ev_time     = ev_valid ? head[TS_WIDTH-1:0]        : '0;
  assign ev_overflow = ovf_reg;
  assign level       = level_reg;

endmodule

// File: tb/tb_watch_monitor.sv
// tb_watch_monitor: directed scenarios with literal expectations, followed by
// randomized stimulus, all compared every cycle against a queue-based
// behavioural model of the monitor.
module tb_watch_monitor;

  localparam int CHANNELS = 7;
  localparam int WIDTH    = 24;
  localparam int DEPTH    = 4;
  localparam int TS_WIDTH = 4;
  localparam int CW       = $clog2(CHANNELS);
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int TS_MOD   = 1 << TS_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst = 1'b1;
  logic                      enable = 1'b1;
  logic                      clear_overflow = 1'b0;
  logic                      ev_ready = 1'b0;
  logic [WIDTH-1:0]          ch [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] watch_in;
  logic                      ev_valid;
  logic [CW-1:0]             ev_chan;
  logic [WIDTH-1:0]          ev_data;
  logic [TS_WIDTH-1:0]       ev_time;
  logic                      ev_overflow;
  logic [LW-1:0]             level;

  always_comb begin
    watch_in = '0;
    for (int c = 0; c < CHANNELS; c++) watch_in[c*WIDTH +: WIDTH] = ch[c];
  end

  watch_monitor #(
    .CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .watch_in(watch_in), .enable(enable),
    .clear_overflow(clear_overflow), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_chan(ev_chan), .ev_data(ev_data), .ev_time(ev_time),
    .ev_overflow(ev_overflow), .level(level)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int               chan;
    logic [WIDTH-1:0] data;
    int               tstamp;
  } ev_t;

  ev_t              m_q[$];
  logic [WIDTH-1:0] m_shadow[CHANNELS];
  bit               m_pend[CHANNELS];
  logic [WIDTH-1:0] m_pdata[CHANNELS];
  int               m_ptime[CHANNELS];
  bit               m_armed;
  int               m_rr;
  int               m_ts;
  bit               m_ovf;

  task automatic model_step();
    bit  popped;
    int  room;
    int  g;
    bit  ovf_set;
    ev_t e;
    if (rst) begin
      m_q.delete();
      for (int c = 0; c < CHANNELS; c++) m_pend[c] = 1'b0;
      m_armed = 1'b0;
      m_rr    = 0;
      m_ts    = 0;
      m_ovf   = 1'b0;
      for (int c = 0; c < CHANNELS; c++) m_shadow[c] = ch[c];
      return;
    end
    popped  = (m_q.size() > 0) && ev_ready;
    room    = DEPTH - m_q.size() + (popped ? 1 : 0);
    g       = -1;
    ovf_set = 1'b0;
    if (room > 0) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (g < 0 && m_pend[(m_rr + k) % CHANNELS]) g = (m_rr + k) % CHANNELS;
      end
    end
    if (popped) void'(m_q.pop_front());
    if (g >= 0) begin
      e.chan = g; e.data = m_pdata[g]; e.tstamp = m_ptime[g];
      m_q.push_back(e);
      m_pend[g] = 1'b0;
      m_rr = (g + 1) % CHANNELS;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (m_armed && enable && ch[c] != m_shadow[c]) begin
        if (m_pend[c]) ovf_set = 1'b1;
        m_pend[c]  = 1'b1;
        m_pdata[c] = ch[c];
        m_ptime[c] = m_ts;
      end
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (clear_overflow) m_ovf = 1'b0;
    for (int c = 0; c < CHANNELS; c++) m_shadow[c] = ch[c];
    m_armed = 1'b1;
    m_ts = (m_ts + 1) % TS_MOD;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Single compare process: outputs settle after the rising edge, read on the falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      bit v;
      v = (m_q.size() > 0);
      check("cmp_valid", ev_valid, v);
      check("cmp_level", level, m_q.size());
      check("cmp_overflow", ev_overflow, m_ovf);
      check("cmp_chan", ev_chan, v ? m_q[0].chan : 0);
      check("cmp_data", ev_data, v ? m_q[0].data : 0);
      check("cmp_time", ev_time, v ? m_q[0].tstamp : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  int               r_chan[$];
  logic [WIDTH-1:0] r_data[$];
  int               r_time[$];

  task automatic record_head();
    r_chan.push_back(int'(ev_chan));
    r_data.push_back(ev_data);
    r_time.push_back(int'(ev_time));
  endtask

  initial begin
    for (int c = 0; c < CHANNELS; c++) ch[c] = '0;
    @(negedge clk);
    tick(2);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_valid", ev_valid, 0);
    check("reset_level", level, 0);
    check("reset_overflow", ev_overflow, 0);
    check("reset_chan", ev_chan, 0);
    check("reset_data", ev_data, 0);
    check("reset_time", ev_time, 0);

    // Baseline: constant inputs generate nothing.
    for (int i = 0; i < 100; i++) begin
      tick(1);
      check("baseline_valid", ev_valid, 0);
      check("baseline_level", level, 0);
      check("baseline_overflow", ev_overflow, 0);
    end

    // Single change detected at ts=5.
    ev_ready = 1'b1;
    do_reset();
    tick(5);
    ch[2] = 24'h00000A;
    tick(1);
    check("single_pending_valid", ev_valid, 0);
    tick(1);
    check("single_valid", ev_valid, 1);
    check("single_level", level, 1);
    check("single_chan", ev_chan, 2);
    check("single_data", ev_data, 24'h00000A);
    check("single_time", ev_time, 5);
    tick(1);
    check("single_drained_valid", ev_valid, 0);
    check("single_drained_level", level, 0);

    // Simultaneous changes on ch0, ch3, ch6.
    ev_ready = 1'b0;
    do_reset();
    tick(2);
    ch[0] = 24'h000101; ch[3] = 24'h000103; ch[6] = 24'h000106;
    tick(1);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      check("simul_level_ramp", level, i);
    end
    tick(1);
    check("simul_level_hold", level, 3);
    ev_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("simul_drain_chan", ev_chan, (i == 0) ? 0 : (i == 1) ? 3 : 6);
      check("simul_drain_time", ev_time, 2);
      tick(1);
    end
    check("simul_empty", level, 0);

    // Full FIFO and coalescing.
    ev_ready = 1'b0;
    do_reset();
    tick(2);
    for (int c = 0; c < 6; c++) ch[c] = 24'h000200 + 24'(c);
    tick(1);
    tick(6);
    check("full_level", level, 4);
    check("full_head_chan", ev_chan, 0);
    check("full_no_overflow", ev_overflow, 0);
    ch[4] = 24'h0ABCDE;
    tick(1);
    check("coalesce_overflow", ev_overflow, 1);
    check("coalesce_level", level, 4);
    r_chan.delete(); r_data.delete(); r_time.delete();
    ev_ready = 1'b1;
    record_head();
    tick(1);
    check("full_pushpop_level", level, 4);
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (ev_valid) record_head();
      tick(1);
    end
    check("drain_count", r_chan.size(), 6);
    if (r_chan.size() == 6) begin
      for (int i = 0; i < 6; i++) check("drain_order", r_chan[i], i);
      check("drain_ch4_data", r_data[4], 24'h0ABCDE);
      check("drain_ch4_time", r_time[4], 9);
      check("drain_ch5_data", r_data[5], 24'h000205);
      check("drain_ch0_time", r_time[0], 2);
    end
    check("overflow_sticky", ev_overflow, 1);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    check("overflow_cleared", ev_overflow, 0);

    // Reset mid-operation.
    ev_ready = 1'b0;
    do_reset();
    tick(2);
    ch[0] = 24'h000300; ch[1] = 24'h000301; ch[2] = 24'h000302;
    tick(1);
    ch[2] = 24'h000399;
    tick(1);
    tick(2);
    check("midrst_pre_level", level, 3);
    check("midrst_pre_overflow", ev_overflow, 1);
    do_reset();
    check("midrst_valid", ev_valid, 0);
    check("midrst_level", level, 0);
    check("midrst_overflow", ev_overflow, 0);
    check("midrst_data", ev_data, 0);
    tick(2);
    ch[1] = 24'h000401;
    tick(2);
    check("midrst_after_chan", ev_chan, 1);
    check("midrst_after_time", ev_time, 2);
    check("midrst_after_data", ev_data, 24'h000401);

    // Enable gating.
    ev_ready = 1'b1;
    do_reset();
    tick(2);
    enable = 1'b0;
    ch[1] = 24'h000501;
    tick(2);
    check("disabled_valid", ev_valid, 0);
    enable = 1'b1;
    tick(3);
    check("reenable_valid", ev_valid, 0);
    check("reenable_level", level, 0);

    // Timestamp wrap.
    ev_ready = 1'b0;
    do_reset();
    tick(15);
    ch[0] = 24'h000600;
    tick(1);
    ch[1] = 24'h000601;
    tick(2);
    check("wrap_level", level, 2);
    check("wrap_first_chan", ev_chan, 0);
    check("wrap_first_time", ev_time, 15);
    ev_ready = 1'b1;
    tick(1);
    check("wrap_second_chan", ev_chan, 1);
    check("wrap_second_time", ev_time, 0);
    tick(2);

    // Randomized phase, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 299) == 0);
      enable         = ($urandom_range(0, 9) != 0);
      clear_overflow = ($urandom_range(0, 19) == 0);
      ev_ready       = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                            : ($urandom_range(0, 3) == 0);
      for (int c = 0; c < CHANNELS; c++) begin
        if ($urandom_range(0, 5) == 0) ch[c] = 24'($urandom_range(0, 3));
      end
      tick(1);
    end
    rst = 1'b0;
    enable = 1'b0;
    clear_overflow = 1'b0;
    ev_ready = 1'b1;
    tick(20);
    check("final_drained", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
